// File: rtl/reg_dst_pipe.sv
// Write-destination select with a DEPTH-stage destination pipeline
// and youngest-first forwarding match against two source addresses.
module reg_dst_pipe #(
   parameter int unsigned AW       = 5,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LINK_REG = 31
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] in_rt,
   input  logic [AW-1:0] in_rd,
   input  logic [1:0]    reg_dst,
   input  logic          reg_write,
   input  logic          stall,
   input  logic          flush,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [AW-1:0] wb_addr,
   output logic          wb_en,
   output logic [2:0]    fwd_rs,
   output logic [2:0]    fwd_rt
);

   logic [DEPTH:1][AW-1:0] addr_q, addr_d;
   logic [DEPTH:1]         valid_q, valid_d;
   logic [AW-1:0]          sel;

   always_comb begin
      sel = in_rt;
      unique case (reg_dst)
         2'd1:    sel = in_rd;
         2'd2:    sel = AW'(LINK_REG);
         default: sel = in_rt;
      endcase
   end

   always_comb begin
      addr_d  = '0;
      valid_d = '0;
      if (!(stall || flush)) begin
         addr_d[1]  = sel;
         valid_d[1] = reg_write && (sel != '0);
      end
      for (int k = 2; k < DEPTH; k++) begin
         if (!flush) begin
            addr_d[k]  = addr_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
      end
      // The committing entry always advances, even across a flush
      addr_d[DEPTH]  = addr_q[DEPTH-1];
      valid_d[DEPTH] = valid_q[DEPTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         valid_q <= '0;
      end else begin
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      fwd_rs = 3'd0;
      fwd_rt = 3'd0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (valid_q[k] && addr_q[k] == rs_addr && rs_addr != '0)
            fwd_rs = 3'(k);
         if (valid_q[k] && addr_q[k] == rt_addr && rt_addr != '0)
            fwd_rt = 3'(k);
      end
   end

   assign wb_addr = addr_q[DEPTH];
   assign wb_en   = valid_q[DEPTH];

endmodule

// File: tb/tb_reg_dst_pipe.sv
// Directed bench for reg_dst_pipe at default parameters
// (AW=5, DEPTH=3, LINK_REG=31).
module tb_reg_dst_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] in_rt, in_rd, rs_addr, rt_addr;
   logic [1:0] reg_dst;
   logic       reg_write, stall, flush;
   logic [4:0] wb_addr;
   logic       wb_en;
   logic [2:0] fwd_rs, fwd_rt;

   int checks = 0;
   int errors = 0;

   reg_dst_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_rt(in_rt), .in_rd(in_rd),
      .reg_dst(reg_dst), .reg_write(reg_write),
      .stall(stall), .flush(flush),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .wb_addr(wb_addr), .wb_en(wb_en),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] dst, input logic we,
                        input logic st, input logic fl);
      in_rt = rt; in_rd = rd; reg_dst = dst;
      reg_write = we; stall = st; flush = fl;
   endtask

   task automatic chk_wb(input string nm, input logic [4:0] ea,
                         input logic ee);
      checks++;
      if (wb_en !== ee || (ee && wb_addr !== ea)) begin
         errors++;
         $display("FAIL %s: wb_en=%0b wb_addr=%0d expected wb_en=%0b wb_addr=%0d",
                  nm, wb_en, wb_addr, ee, ea);
      end
   endtask

   task automatic chk_fwd(input string nm, input logic [2:0] ers,
                          input logic [2:0] ert);
      checks++;
      if (fwd_rs !== ers || fwd_rt !== ert) begin
         errors++;
         $display("FAIL %s: fwd_rs=%0d fwd_rt=%0d expected %0d %0d",
                  nm, fwd_rs, fwd_rt, ers, ert);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(5'd0, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0);
      rs_addr = 5'd7; rt_addr = 5'd7;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_wb("reset_wb", 5'd0, 1'b0);
         checks++;
         if (wb_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_addr: wb_addr=%0d expected 0", wb_addr);
         end
         chk_fwd("reset_fwd", 3'd0, 3'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      rs_addr = 5'd0; rt_addr = 5'd0;
      tick();
   endtask

   task automatic test_select();
      logic [4:0] exp_a [4];
      exp_a = '{5'd4, 5'd9, 5'd31, 5'd4};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(5'd4, 5'd9, 2'(i), 1'b1, 1'b0, 1'b0);
         else       drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         tick();
         if (i >= 2) chk_wb("select", exp_a[i-2], 1'b1);
      end
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_wb("select_drain", 5'd0, 1'b0);
   endtask

   task automatic test_reg0();
      drive(5'd3, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      chk_fwd("reg0_fwd", 3'd0, 3'd0);
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk_wb("reg0_wb", 5'd0, 1'b0);
      tick();
   endtask

   task automatic test_forward();
      drive(5'd5, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd0, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd8, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      rs_addr = 5'd5; rt_addr = 5'd8;
      #1;
      chk_fwd("fwd_prio", 3'd2, 3'd1);
      tick();
      chk_fwd("fwd_bubble", 3'd3, 3'd2);
      tick();
      chk_fwd("fwd_depth", 3'd0, 3'd3);
      chk_wb("fwd_wb", 5'd8, 1'b1);
      tick();
      rs_addr = 5'd0; rt_addr = 5'd0;
   endtask

   task automatic test_stall_flush();
      drive(5'd7, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0); tick();
      rs_addr = 5'd7;
      #1;
      chk_fwd("stall_bubble", 3'd0, 3'd0);
      drive(5'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd6, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd10, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      rs_addr = 5'd10; rt_addr = 5'd3;
      #1;
      chk_fwd("sf_fill", 3'd1, 3'd3);
      chk_wb("sf_fill_wb", 5'd3, 1'b1);
      drive(5'd12, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1); tick();
      chk_wb("sf_commit", 5'd6, 1'b1);
      rt_addr = 5'd6;
      #1;
      chk_fwd("sf_fwd", 3'd0, 3'd3);
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_wb("sf_after1", 5'd0, 1'b0);
      tick();
      chk_wb("sf_after2", 5'd0, 1'b0);
      rs_addr = 5'd0; rt_addr = 5'd0;
   endtask

   task automatic test_async_reset();
      drive(5'd20, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      tick();
      chk_wb("ar_before", 5'd20, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_wb("ar_drop", 5'd0, 1'b0);
      checks++;
      if (wb_addr !== 5'd0) begin
         errors++;
         $display("FAIL ar_addr: wb_addr=%0d expected 0", wb_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_select();
      test_reg0();
      test_forward();
      test_stall_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_dst_pipe.md
# reg_dst_pipe

Parametrised successor to the register-file write-destination mux, built for the move from the single-cycle datapath to a pipelined one. Each cycle it selects the write-destination register from rt, rd or the link register and carries the selected address and its write-enable down a DEPTH-stage shift pipeline to the register-file write port. It also compares two decode-stage source addresses against every in-flight destination and reports the youngest matching stage, which is the forwarding select for the ALU operand muxes.

## Interface
- AW, 5, register address width.
- DEPTH, 3, number of pipeline stages from the select point to write-back; legal range 2..7.
- LINK_REG, 31, destination used for link (jal-type) writes.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_rt  input  AW  rt field of the issuing instruction.
- in_rd  input  AW  rd field of the issuing instruction.
- reg_dst  input  2  destination select: 0 = rt, 1 = rd, 2 = LINK_REG, 3 = reserved, treated as rt.
- reg_write  input  1  the issuing instruction writes the register file.
- stall  input  1  hold decode; a bubble enters stage 1.
- flush  input  1  kill wrong-path instructions in stages 1..DEPTH-1.
- rs_addr  input  AW  decode-stage source address A.
- rt_addr  input  AW  decode-stage source address B.
- wb_addr  output  AW  write-back address; this is the stage DEPTH address.
- wb_en  output  1  write-back enable; this is the stage DEPTH valid bit.
- fwd_rs  output  3  forwarding select for rs_addr: 0 = none, k = stage k.
- fwd_rt  output  3  forwarding select for rt_addr, same encoding as fwd_rs.

## Operation
- Each stage k (1..DEPTH) holds addr[k] (AW bits) and valid[k].
- Select: sel = rd if reg_dst=1, LINK_REG if reg_dst=2, otherwise rt.
- Stage-1 load: valid is set to reg_write & (sel != 0), so writes to register 0 never enter as valid. addr is set to sel.
- Stall: stage 1 loads valid=0, addr=0. Stages 2..DEPTH advance normally.
- Flush: valid[1..DEPTH-1] clear to 0 on the edge and their addr fields clear to 0. Stage DEPTH still loads from stage DEPTH-1 as it was before the edge, so the instruction about to commit is not lost.
- Stall and flush together: flush behaviour applies, and stage 1 takes a bubble.
- Otherwise, addr[k] and valid[k] load from stage k-1 for k = 2..DEPTH.
- Forwarding: fwd_rs = smallest k with valid[k] & addr[k]==rs_addr & rs_addr!=0, else 0. fwd_rt is computed the same way from rt_addr. The result is combinational from the stage registers and the query inputs. The youngest stage has priority.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert recommended externally): all valid=0 and all addr=0. Consequently wb_addr=0, wb_en=0, fwd_rs=0, fwd_rt=0.
- Reset asserted mid-operation discards all in-flight entries immediately, with no write-back pulse.
- Latency: inputs sampled at edge E appear on wb_addr/wb_en after edge E+DEPTH-1, which is exactly DEPTH edges of residence including the load edge.
- Throughput: one instruction per cycle. No backpressure beyond stall.
- fwd_rs and fwd_rt settle in the same cycle as a query change. Their only registered dependency is the stage contents.
- Wrap-around: none; entries fall off after stage DEPTH.
- An address match with the stage-DEPTH entry returns DEPTH. The register file must also see that write this cycle; write-before-read is the register file's responsibility.

## Test plan
- Reset: hold rst_n=0 with reg_write=1, in_rd=7, reg_dst=1, toggling clk -> wb_en=0, wb_addr=0 and fwd_rs=fwd_rt=0 throughout.
- Select and latency (DEPTH=3): issue in_rt=4, in_rd=9 with reg_dst=0,1,2,3 on consecutive cycles with reg_write=1 -> wb_addr shows 4, 9, 31, 4 after 3 edges each, with wb_en=1 for all.
- Register 0 suppression: reg_dst=1, in_rd=0, reg_write=1 -> wb_en=0 at write-back, and query rs_addr=0 gives fwd_rs=0.
- Forward priority: issue writes to 5, then 5, then 8. Query rs_addr=5, rt_addr=8 -> fwd_rs=2 and fwd_rt=1. After one more bubble -> fwd_rs=3 and fwd_rt=2.
- Stall and flush: pipeline holds writes to 3, 6, 10 (stage 3→1). Assert flush and stall for one edge -> stage 3 becomes 6 with valid=1, stages 1..2 are invalid, and wb_addr=6, wb_en=1 follows. The next two cycles give wb_en=0.
- Async reset mid-stream: drop rst_n between edges while wb_en=1 -> wb_en falls immediately, without waiting for a clock edge.
